// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one byte at a time and serialises each byte as a UART frame on tx.
// Optional even-parity bit (8E1) enabled by defining FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic       fifo_full,
    input  logic       fifo_wr,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [7:0] last_byte
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    last_q, last_d;
    logic          tx_q, tx_d;
    logic          rd_q, rd_d;
    logic          baud_last;
    logic          accept;

    assign baud_last = (baud_q == BAUD_LAST);
    // A rd issued alongside an accepted write is dropped by the FIFO, so treat it as not popped.
    assign accept    = !fifo_empty && !(fifo_wr && !fifo_full);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            last_q  <= '0;
            tx_q    <= 1'b1;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        last_d  = last_q;
        tx_d    = tx_q;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (enable && !fifo_empty) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = accept ? S_LOAD : S_IDLE;
            end
            S_LOAD: begin
                shift_d = fifo_dout;
                last_d  = fifo_dout;
                baud_d  = '0;
                bit_d   = '0;
                tx_d    = 1'b0;
                state_d = S_START;
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        tx_d    = ^last_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        // tx is registered, so present the following bit one cycle early.
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`endif
            S_STOP: begin
                tx_d = 1'b1;
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
        rd_d = (state_d == S_REQ);
    end

    assign fifo_rd   = rd_q;
    assign tx        = tx_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_STOP) && baud_last;
    assign last_byte = last_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-based FIFO model feeds the DUT and a frame-timing model predicts tx/done.
module tb_fifo_uart_tx;

    localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       fifo_empty = 1'b1;
    logic       fifo_full = 1'b0;
    logic       fifo_wr = 1'b0;
    logic [7:0] fifo_dout = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic       fifo_rd, tx, busy, done;
    logic [7:0] last_byte;

    fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
        .fifo_dout(fifo_dout), .fifo_rd(fifo_rd), .tx(tx), .busy(busy),
        .done(done), .last_byte(last_byte)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line level p cycles after the pop edge (p=0 is the LOAD cycle).
    function automatic logic exp_tx(input int p, input logic [7:0] b);
        int i;
        if (p == 0) return 1'b1;
        i = (p - 1) / C;
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef FIFO_UART_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    logic [7:0] q[$];
    logic [7:0] popped[$];
    logic [7:0] written[$];
    bit         active = 1'b0;
    int         ph = 0;
    logic [7:0] exp_byte = 8'h00;

    always @(posedge clk) begin : fifo_model
        bit wr_ok;
        bit rd_ok;
        logic [7:0] b;
        b = 8'h00;
        wr_ok = fifo_wr && (q.size() < 16);
        rd_ok = fifo_rd && (q.size() > 0) && !wr_ok;
        if (rd_ok) begin
            b = q.pop_front();
            fifo_dout <= b;
            popped.push_back(b);
        end
        if (wr_ok) q.push_back(wr_data);
        fifo_empty <= (q.size() == 0);
        fifo_full  <= (q.size() == 16);
        if (rst) active <= 1'b0;
        else if (rd_ok) begin
            active   <= 1'b1;
            ph       <= 0;
            exp_byte <= b;
        end else if (active) begin
            if (ph == NB * C) active <= 1'b0;
            else ph <= ph + 1;
        end
    end

    int   cyc = 0;
    int   fall_cyc = 0;
    int   last_done_cyc = -1;
    int   n_done = 0;
    int   n_rd = 0;
    bit   in_frame = 1'b0;
    bit   gap_arm = 1'b0;
    bit   chk_on = 1'b0;
    logic prev_tx = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (chk_on) begin
            if (fifo_rd) n_rd++;
            if (active) begin
                chk("tx_model", tx, exp_tx(ph, exp_byte));
                chk("busy_frame", busy, 1);
                chk("rd_in_frame", fifo_rd, 0);
                chk("done_model", done, ph == NB * C);
            end else begin
                chk("tx_idle", tx, 1);
                chk("done_idle", done, 0);
            end
            if (prev_tx && !tx && !in_frame) begin
                in_frame = 1'b1;
                fall_cyc = cyc;
                if (gap_arm && last_done_cyc >= 0) chk("gap", cyc - last_done_cyc, 4);
            end
            if (done) begin
                n_done++;
                chk("frame_len", in_frame ? cyc - fall_cyc : -1, NB * C - 1);
                last_done_cyc = cyc;
                in_frame = 1'b0;
            end
            if (!busy) in_frame = 1'b0;
        end
        prev_tx = tx;
    end

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        fifo_wr = 1'b1;
        wr_data = b;
        written.push_back(b);
        @(negedge clk);
        fifo_wr = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            if (!busy && fifo_empty && !active && !fifo_wr) ok = 1'b1;
        end
        chk({name, "_timeout"}, ok, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk({name, "_idle_busy"}, busy, 0);
            chk({name, "_idle_rd"}, fifo_rd, 0);
        end
    endtask

    // Expects an idle DUT with an empty FIFO; bits[k] is the k-th bit on the line.
    task automatic send_sample(input logic [7:0] b, input logic [10:0] bits, input string name);
        push(b);
        @(negedge clk);
        chk({name, "_rd_pulse"}, fifo_rd, 1);
        @(negedge clk);
        chk({name, "_load_tx"}, tx, 1);
        chk({name, "_load_busy"}, busy, 1);
        @(negedge clk);
        for (int k = 0; k < NB; k++) begin
            chk({name, "_bit"}, tx, bits[k]);
            repeat (C) @(negedge clk);
        end
        wait_idle(name);
        chk({name, "_last_byte"}, last_byte, b);
    endtask

    initial begin
        int rd0;
        bit seen;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_rd", fifo_rd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_last", last_byte, 8'h00);
        rst = 1'b0;
        enable = 1'b1;
        chk_on = 1'b1;

        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("empty_tx", tx, 1);
            chk("empty_rd", fifo_rd, 0);
            chk("empty_busy", busy, 0);
        end

        rd0 = n_rd;
`ifdef FIFO_UART_TX_PARITY_EN
        send_sample(8'hA5, 11'b1_0_10100101_0, "a5");
`else
        send_sample(8'hA5, 11'b0_1_10100101_0, "a5");
`endif
        chk("a5_rd_count", n_rd - rd0, 1);
        chk("a5_done_count", n_done, 1);

        // Collision: a write lands in the REQ cycle, so the pop must be retried.
        push(8'h11);
        @(negedge clk);
        chk("col_req1", fifo_rd, 1);
        fifo_wr = 1'b1;
        wr_data = 8'h22;
        written.push_back(8'h22);
        @(negedge clk);
        fifo_wr = 1'b0;
        chk("col_idle_rd", fifo_rd, 0);
        chk("col_idle_busy", busy, 0);
        @(negedge clk);
        chk("col_req2", fifo_rd, 1);
        wait_idle("col");
        chk("col_last", last_byte, 8'h22);
        chk("col_done_count", n_done, 3);

        enable = 1'b0;
        for (int i = 0; i < 16; i++) push(8'(i));
        gap_arm = 1'b1;
        last_done_cyc = -1;
        enable = 1'b1;
        wait_idle("burst");
        gap_arm = 1'b0;
        chk("burst_done_count", n_done, 19);
        chk("burst_last", last_byte, 8'h0F);

        enable = 1'b0;
        push(8'h3C);
        push(8'h55);
        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (!tx) seen = 1'b1;
        end
        chk("rst_frame_start", seen, 1);
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", busy, 0);
        wait_idle("midrst");
        chk("midrst_done_count", n_done, 20);
        chk("midrst_last", last_byte, 8'h55);

`ifdef FIFO_UART_TX_PARITY_EN
        send_sample(8'h07, 11'b1_1_00000111_0, "par07");
        send_sample(8'h03, 11'b1_0_00000011_0, "par03");
        chk("par_done_count", n_done, 22);
`endif

        chk("sb_count", popped.size(), written.size());
        for (int i = 0; i < popped.size() && i < written.size(); i++) begin
            chk("sb_order", popped[i], written[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the 16-entry, 8-bit synchronous FIFO. Pops one byte at a time through the FIFO's rd/dout/empty handshake (dout registered one cycle after rd) and serialises it as an 8N1 UART frame on `tx`. It detects the FIFO's write-over-read priority, where a rd in the same cycle as an accepted wr is ignored, and retries the pop.

## Interface
- `CLKS_PER_BIT`, default 16: clk cycles per UART bit; legal range 2..65535.
- `clk  in  1`: clock, all logic on rising edge.
- `rst  in  1`: reset, synchronous, active-high.
- `enable  in  1`: permits starting a new pop; an in-flight frame always completes.
- `fifo_empty  in  1`: FIFO empty flag.
- `fifo_full  in  1`: FIFO full flag.
- `fifo_wr  in  1`: monitored copy of the FIFO's wr request, used for collision detection.
- `fifo_dout  in  8`: FIFO read data.
- `fifo_rd  out  1`: FIFO read strobe, registered.
- `tx  out  1`: serial line, registered; idle high.
- `busy  out  1`: high in every state except IDLE.
- `done  out  1`: one-cycle pulse on the last cycle of STOP.
- `last_byte  out  8`: most recently captured byte.

## Operation
- States: IDLE, REQ, LOAD, START, DATA, PARITY (only with macro), STOP.
- IDLE: if `enable && !fifo_empty`, go to REQ. `fifo_rd` is driven high during the REQ cycle only.
- REQ, acceptance check in the same cycle: `accept = !fifo_empty && !(fifo_wr && !fifo_full)`.
  - accept = 1: go to LOAD.
  - accept = 0: go to IDLE and retry. No byte is lost because the FIFO did not pop.
- LOAD: capture `fifo_dout` into the shift register and into `last_byte`, then go to START.
- START: `tx` = 0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles.
  - A 3-bit bit counter counts 0..7.
  - The baud counter is `$clog2(CLKS_PER_BIT)` bits wide, counts 0..CLKS_PER_BIT-1, and reloads on every bit boundary.
- STOP: `tx` = 1 for CLKS_PER_BIT cycles. `done` = 1 on the final cycle, then go to IDLE.
- `enable` falling mid-frame does not abort the frame; it only blocks the next REQ.
- Only one pop is outstanding at a time. The block never asserts `fifo_rd` outside REQ.

## Timing
- Reset values: `tx`=1, `fifo_rd`=0, `busy`=0, `done`=0, `last_byte`=8'h00, state IDLE, all counters 0.
- Reset mid-frame: on the next edge `tx`=1 and state is IDLE. The partially sent byte is dropped, because it was already popped.
- Pop latency:
  - IDLE sees a non-empty FIFO at edge n.
  - `fifo_rd`=1 during cycle n+1.
  - `fifo_dout` is valid and captured in LOAD at cycle n+2.
  - `tx` falls at the start of cycle n+3.
- Frame length: 10×CLKS_PER_BIT cycles, or 11×CLKS_PER_BIT with parity.
- Inter-frame gap with a non-empty FIFO: exactly 3 cycles of `tx`=1 (IDLE, REQ, LOAD) between the STOP end and the next START.
- Failed-acceptance retry adds 2 cycles per collision. It repeats indefinitely while collisions persist.
- FIFO goes empty exactly after the pop: the block returns to IDLE after STOP and stays there with `tx`=1.

## Configuration
- Macro `FIFO_UART_TX_PARITY_EN`.
- Defined: a PARITY state is inserted between DATA and STOP.
  - `tx` = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
  - The frame becomes 8E1.
- Undefined: the PARITY state and its logic are absent; frame is 8N1.

## Test plan
- Reset, CLKS_PER_BIT=4, FIFO empty, enable=1 for 50 cycles -> `tx`=1, `fifo_rd`=0, `busy`=0 throughout.
- Write 8'hA5 to the FIFO, then idle -> one `fifo_rd` pulse; `tx` sequence 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles wide; `done` pulses once; `last_byte`=8'hA5; FIFO empty.
- Fill FIFO with 16 bytes 8'h00..8'h0F -> 16 frames in order, each separated by exactly 3 idle cycles; 16 `done` pulses; the final IDLE holds.
- Assert `fifo_wr` (FIFO not full) in the same cycle as REQ -> no LOAD; REQ retried 2 cycles later; byte sent once, with no duplicate and no loss.
- Assert `rst` in the 3rd DATA bit of 8'h3C -> `tx`=1 on the next edge; no `done`; the next queued byte is sent normally after reset.
- With `FIFO_UART_TX_PARITY_EN` defined, send 8'h07 -> parity bit 1, frame 44 cycles; send 8'h03 -> parity bit 0.
